// File: rtl/id_stage_if.sv
// id_stage_if: ID-stage signal bundle.
// master: drives instruction, PC, WB and EX inputs; receives decode results.
// slave:  the id_stage itself.
interface id_stage_if;
    // Inputs to ID
    logic [31:0] Instruction_id;
    logic [31:0] NextPC_id;
    logic        RegWrite_wb;
    logic [4:0]  RegWriteAddr_wb;
    logic [31:0] RegWriteData_wb;
    logic        MemRead_ex;
    logic [4:0]  RegWriteAddr_ex;
    // Outputs from ID
    logic        MemtoReg_id;
    logic        RegWrite_id;
    logic        MemWrite_id;
    logic        MemRead_id;
    logic [4:0]  ALUCode_id;
    logic        ALUSrcA_id;
    logic        ALUSrcB_id;
    logic        RegDst_id;
    logic        Stall;
    logic        PC_IFWrite;
    logic        Z;
    logic        J;
    logic        JR;
    logic [31:0] BranchAddr;
    logic [31:0] JumpAddr;
    logic [31:0] JrAddr;
    logic [31:0] Imm_id;
    logic [31:0] Sa_id;
    logic [31:0] RsData_id;
    logic [31:0] RtData_id;
    logic [4:0]  RsAddr_id;
    logic [4:0]  RtAddr_id;
    logic [4:0]  RdAddr_id;

    modport master (
        output Instruction_id, NextPC_id, RegWrite_wb, RegWriteAddr_wb, RegWriteData_wb,
               MemRead_ex, RegWriteAddr_ex,
        input  MemtoReg_id, RegWrite_id, MemWrite_id, MemRead_id, ALUCode_id, ALUSrcA_id,
               ALUSrcB_id, RegDst_id, Stall, PC_IFWrite, Z, J, JR, BranchAddr, JumpAddr,
               JrAddr, Imm_id, Sa_id, RsData_id, RtData_id, RsAddr_id, RtAddr_id, RdAddr_id
    );

    modport slave (
        input  Instruction_id, NextPC_id, RegWrite_wb, RegWriteAddr_wb, RegWriteData_wb,
               MemRead_ex, RegWriteAddr_ex,
        output MemtoReg_id, RegWrite_id, MemWrite_id, MemRead_id, ALUCode_id, ALUSrcA_id,
               ALUSrcB_id, RegDst_id, Stall, PC_IFWrite, Z, J, JR, BranchAddr, JumpAddr,
               JrAddr, Imm_id, Sa_id, RsData_id, RtData_id, RsAddr_id, RtAddr_id, RdAddr_id
    );
endinterface

// File: rtl/id_stage.sv
// id_stage: MIPS instruction-decode stage with register file, branch/jump
// resolution and load-use stall detection. All outputs are combinational.
// Optional macro ID_BYPASS_EN: WB write data is forwarded to same-cycle reads.
module id_stage (
    input  logic      clk,
    input  logic      rst_n,
    id_stage_if.slave bus
);
    localparam logic [4:0] AluAdd  = 5'd0;
    localparam logic [4:0] AluAnd  = 5'd1;
    localparam logic [4:0] AluXor  = 5'd2;
    localparam logic [4:0] AluOr   = 5'd3;
    localparam logic [4:0] AluNor  = 5'd4;
    localparam logic [4:0] AluSub  = 5'd5;
    localparam logic [4:0] AluAndi = 5'd6;
    localparam logic [4:0] AluXori = 5'd7;
    localparam logic [4:0] AluOri  = 5'd8;
    localparam logic [4:0] AluSll  = 5'd16;
    localparam logic [4:0] AluSrl  = 5'd17;
    localparam logic [4:0] AluSra  = 5'd18;
    localparam logic [4:0] AluSlt  = 5'd19;
    localparam logic [4:0] AluSltu = 5'd20;

    logic [31:0] instr;
    logic [5:0]  opcode, funct;
    logic [4:0]  rsAddr, rtAddr;
    logic [15:0] imm;
    logic [31:0] regFile [32];
    logic [31:0] rsData, rtData;

    // Decoded controls before stall gating
    logic       rawRegWrite, rawMemRead, rawMemWrite;
    logic       isBeq, isBne, isJ, isJr, zeroExt;
    logic [4:0] aluCode;
    logic       aluSrcA, aluSrcB, regDst;
    logic       stall;

    assign instr  = bus.Instruction_id;
    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign rsAddr = instr[25:21];
    assign rtAddr = instr[20:16];
    assign imm    = instr[15:0];

    // Register file: async clear, write from WB on rising edge; $0 never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regFile[i] <= '0;
        end else if (bus.RegWrite_wb && (bus.RegWriteAddr_wb != 5'd0)) begin
            regFile[bus.RegWriteAddr_wb] <= bus.RegWriteData_wb;
        end
    end

    // Register reads, $0 hardwired to zero, optional same-cycle WB forwarding
    always_comb begin
        rsData = (rsAddr == 5'd0) ? '0 : regFile[rsAddr];
        rtData = (rtAddr == 5'd0) ? '0 : regFile[rtAddr];
`ifdef ID_BYPASS_EN
        // Reset holds reads at zero, so forwarding is suppressed while in reset
        if (rst_n && bus.RegWrite_wb && (bus.RegWriteAddr_wb != 5'd0)) begin
            if (bus.RegWriteAddr_wb == rsAddr) rsData = bus.RegWriteData_wb;
            if (bus.RegWriteAddr_wb == rtAddr) rtData = bus.RegWriteData_wb;
        end
`endif
    end

    // Instruction decode; unsupported encodings fall through as NOP
    always_comb begin
        rawRegWrite = 1'b0;
        rawMemRead  = 1'b0;
        rawMemWrite = 1'b0;
        isBeq       = 1'b0;
        isBne       = 1'b0;
        isJ         = 1'b0;
        isJr        = 1'b0;
        zeroExt     = 1'b0;
        aluCode     = AluAdd;
        aluSrcA     = 1'b0;
        aluSrcB     = 1'b0;
        regDst      = 1'b0;
        case (opcode)
            6'h00: begin
                regDst      = 1'b1;
                rawRegWrite = 1'b1;
                case (funct)
                    6'h20, 6'h21: aluCode = AluAdd;
                    6'h22, 6'h23: aluCode = AluSub;
                    6'h24:        aluCode = AluAnd;
                    6'h25:        aluCode = AluOr;
                    6'h26:        aluCode = AluXor;
                    6'h27:        aluCode = AluNor;
                    6'h2a:        aluCode = AluSlt;
                    6'h2b:        aluCode = AluSltu;
                    6'h00: begin aluCode = AluSll; aluSrcA = 1'b1; end
                    6'h02: begin aluCode = AluSrl; aluSrcA = 1'b1; end
                    6'h03: begin aluCode = AluSra; aluSrcA = 1'b1; end
                    6'h08: begin isJr = 1'b1; rawRegWrite = 1'b0; end
                    default: begin regDst = 1'b0; rawRegWrite = 1'b0; end
                endcase
            end
            6'h08, 6'h09: begin rawRegWrite = 1'b1; aluSrcB = 1'b1; end
            6'h0a: begin rawRegWrite = 1'b1; aluSrcB = 1'b1; aluCode = AluSlt; end
            6'h0b: begin rawRegWrite = 1'b1; aluSrcB = 1'b1; aluCode = AluSltu; end
            6'h0c: begin
                rawRegWrite = 1'b1; aluSrcB = 1'b1; aluCode = AluAndi; zeroExt = 1'b1;
            end
            6'h0d: begin
                rawRegWrite = 1'b1; aluSrcB = 1'b1; aluCode = AluOri; zeroExt = 1'b1;
            end
            6'h0e: begin
                rawRegWrite = 1'b1; aluSrcB = 1'b1; aluCode = AluXori; zeroExt = 1'b1;
            end
            6'h23: begin rawRegWrite = 1'b1; rawMemRead = 1'b1; aluSrcB = 1'b1; end
            6'h2b: begin rawMemWrite = 1'b1; aluSrcB = 1'b1; end
            6'h04: isBeq = 1'b1;
            6'h05: isBne = 1'b1;
            6'h02: isJ = 1'b1;
            default: ;
        endcase
    end

    // Load-use hazard: EX load targets a register this instruction names
    always_comb begin
        stall = bus.MemRead_ex && (bus.RegWriteAddr_ex != 5'd0) &&
                ((bus.RegWriteAddr_ex == rsAddr) || (bus.RegWriteAddr_ex == rtAddr));
    end

    assign bus.Stall       = stall;
    assign bus.PC_IFWrite  = ~stall;
    assign bus.RegWrite_id = rawRegWrite & ~stall;
    assign bus.MemRead_id  = rawMemRead & ~stall;
    assign bus.MemtoReg_id = rawMemRead & ~stall;
    assign bus.MemWrite_id = rawMemWrite & ~stall;
    assign bus.ALUCode_id  = aluCode;
    assign bus.ALUSrcA_id  = aluSrcA;
    assign bus.ALUSrcB_id  = aluSrcB;
    assign bus.RegDst_id   = regDst;
    assign bus.Z           = ~stall & ((isBeq & (rsData == rtData)) | (isBne & (rsData != rtData)));
    assign bus.J           = isJ & ~stall;
    assign bus.JR          = isJr & ~stall;
    assign bus.Imm_id      = zeroExt ? {16'b0, imm} : {{16{imm[15]}}, imm};
    assign bus.Sa_id       = {27'b0, instr[10:6]};
    assign bus.BranchAddr  = bus.NextPC_id + {{14{imm[15]}}, imm, 2'b00};
    assign bus.JumpAddr    = {bus.NextPC_id[31:28], instr[25:0], 2'b00};
    assign bus.JrAddr      = rsData;
    assign bus.RsData_id   = rsData;
    assign bus.RtData_id   = rtData;
    assign bus.RsAddr_id   = rsAddr;
    assign bus.RtAddr_id   = rtAddr;
    assign bus.RdAddr_id   = instr[15:11];
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: randomized self-checking bench for id_stage against a
// table-driven instruction model and an array register-file model.
module tb_id_stage;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    bit   cmpEn  = 1'b0;

    always #5 clk = ~clk;

    id_stage_if bus ();

    id_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Instruction table: kind 0 plain, 1 beq, 2 bne, 3 j, 4 jr; fn -1 for non R-type
    typedef struct {
        int op; int fn; int alu; int rw; int mr; int mw; int rd; int sa; int sb; int zx; int kind;
    } row_t;
    row_t rows [26];

    typedef struct {
        logic [31:0] memtoReg, regWrite, memWrite, memRead, aluCode, srcA, srcB, regDst;
        logic [31:0] stall, pcWrite, z, j, jr, branch, jump, jrAddr, imm, sa, rsd, rtd;
        logic [31:0] rsA, rtA, rdA;
    } exp_t;

    logic [31:0] mregs [32];

    // Reference register file
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) mregs[i] <= '0;
        end else if (bus.RegWrite_wb && bus.RegWriteAddr_wb != 0) begin
            mregs[bus.RegWriteAddr_wb] <= bus.RegWriteData_wb;
        end
    end

    function automatic logic [31:0] readReg(input int a);
        logic [31:0] v;
        if (a == 0 || !rst_n) return 32'd0;
        v = mregs[a];
`ifdef ID_BYPASS_EN
        if (bus.RegWrite_wb && bus.RegWriteAddr_wb != 0 && int'(bus.RegWriteAddr_wb) == a)
            v = bus.RegWriteData_wb;
`endif
        return v;
    endfunction

    function automatic exp_t model();
        exp_t e;
        logic [31:0] ins, pc;
        int op, fn, rs, rt, hit, sImm;
        logic st;
        row_t r;
        ins  = bus.Instruction_id;
        pc   = bus.NextPC_id;
        op   = int'(ins >> 26);
        fn   = int'(ins & 32'h3f);
        rs   = int'((ins >> 21) & 32'h1f);
        rt   = int'((ins >> 16) & 32'h1f);
        hit  = -1;
        for (int i = 0; i < 26; i++)
            if (rows[i].op == op && (rows[i].fn < 0 || rows[i].fn == fn)) hit = i;
        r = '{0, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        if (hit >= 0) r = rows[hit];
        st = bus.MemRead_ex && bus.RegWriteAddr_ex != 0 &&
             (int'(bus.RegWriteAddr_ex) == rs || int'(bus.RegWriteAddr_ex) == rt);
        e.rsd      = readReg(rs);
        e.rtd      = readReg(rt);
        e.stall    = 32'(st);
        e.pcWrite  = 32'(!st);
        e.regWrite = st ? 0 : 32'(r.rw);
        e.memRead  = st ? 0 : 32'(r.mr);
        e.memtoReg = st ? 0 : 32'(r.mr);
        e.memWrite = st ? 0 : 32'(r.mw);
        e.aluCode  = 32'(r.alu);
        e.srcA     = 32'(r.sa);
        e.srcB     = 32'(r.sb);
        e.regDst   = 32'(r.rd);
        e.z        = 32'(!st && ((r.kind == 1 && e.rsd == e.rtd) || (r.kind == 2 && e.rsd != e.rtd)));
        e.j        = 32'(!st && r.kind == 3);
        e.jr       = 32'(!st && r.kind == 4);
        sImm       = int'($signed(ins[15:0]));
        e.imm      = r.zx != 0 ? (ins & 32'hffff) : 32'(sImm);
        e.branch   = pc + 32'(sImm * 4);
        e.jump     = (pc & 32'hf000_0000) | ((ins & 32'h03ff_ffff) << 2);
        e.jrAddr   = e.rsd;
        e.sa       = (ins >> 6) & 32'h1f;
        e.rsA      = 32'(rs);
        e.rtA      = 32'(rt);
        e.rdA      = (ins >> 11) & 32'h1f;
        return e;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h (instr %h)", name, $time, act, exp,
                     bus.Instruction_id);
        end
    endtask

    task automatic checkAll();
        exp_t e;
        e = model();
        check32("MemtoReg", 32'(bus.MemtoReg_id), e.memtoReg);
        check32("RegWrite", 32'(bus.RegWrite_id), e.regWrite);
        check32("MemWrite", 32'(bus.MemWrite_id), e.memWrite);
        check32("MemRead", 32'(bus.MemRead_id), e.memRead);
        check32("ALUCode", 32'(bus.ALUCode_id), e.aluCode);
        check32("ALUSrcA", 32'(bus.ALUSrcA_id), e.srcA);
        check32("ALUSrcB", 32'(bus.ALUSrcB_id), e.srcB);
        check32("RegDst", 32'(bus.RegDst_id), e.regDst);
        check32("Stall", 32'(bus.Stall), e.stall);
        check32("PC_IFWrite", 32'(bus.PC_IFWrite), e.pcWrite);
        check32("Z", 32'(bus.Z), e.z);
        check32("J", 32'(bus.J), e.j);
        check32("JR", 32'(bus.JR), e.jr);
        check32("BranchAddr", bus.BranchAddr, e.branch);
        check32("JumpAddr", bus.JumpAddr, e.jump);
        check32("JrAddr", bus.JrAddr, e.jrAddr);
        check32("Imm_id", bus.Imm_id, e.imm);
        check32("Sa_id", bus.Sa_id, e.sa);
        check32("RsData", bus.RsData_id, e.rsd);
        check32("RtData", bus.RtData_id, e.rtd);
        check32("RsAddr", 32'(bus.RsAddr_id), e.rsA);
        check32("RtAddr", 32'(bus.RtAddr_id), e.rtA);
        check32("RdAddr", 32'(bus.RdAddr_id), e.rdA);
    endtask

    // Model comparison on every falling edge
    always @(negedge clk) if (cmpEn) checkAll();

    task automatic setIn(input logic [31:0] ins, input logic [31:0] pc);
        @(posedge clk);
        #1;
        bus.Instruction_id = ins;
        bus.NextPC_id      = pc;
        #1;
    endtask

    task automatic randomCycle();
        logic [31:0] ins;
        int idx, rs, rt;
        @(posedge clk);
        #1;
        rs = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 7) : $urandom_range(0, 31);
        rt = ($urandom_range(0, 9) < 3) ? rs : $urandom_range(0, 31);
        if ($urandom_range(0, 9) == 0) begin
            ins = $urandom;
        end else begin
            idx = $urandom_range(0, 25);
            ins = $urandom;
            ins[31:26] = 6'(rows[idx].op);
            ins[25:21] = 5'(rs);
            ins[20:16] = 5'(rt);
            if (rows[idx].fn >= 0) ins[5:0] = 6'(rows[idx].fn);
        end
        bus.Instruction_id  = ins;
        bus.NextPC_id       = $urandom;
        bus.RegWrite_wb     = 1'($urandom_range(0, 1));
        bus.RegWriteAddr_wb = ($urandom_range(0, 3) == 0) ? 5'(rs) : 5'($urandom_range(0, 7));
        bus.RegWriteData_wb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        bus.MemRead_ex      = ($urandom_range(0, 3) == 0);
        bus.RegWriteAddr_ex = ($urandom_range(0, 1) == 0) ? ins[25:21 - 0] & 5'h1f
                                                           : 5'($urandom_range(0, 31));
    endtask

    initial begin
        rows[0]  = '{0, 'h20, 0,  1, 0, 0, 1, 0, 0, 0, 0};
        rows[1]  = '{0, 'h21, 0,  1, 0, 0, 1, 0, 0, 0, 0};
        rows[2]  = '{0, 'h22, 5,  1, 0, 0, 1, 0, 0, 0, 0};
        rows[3]  = '{0, 'h23, 5,  1, 0, 0, 1, 0, 0, 0, 0};
        rows[4]  = '{0, 'h24, 1,  1, 0, 0, 1, 0, 0, 0, 0};
        rows[5]  = '{0, 'h25, 3,  1, 0, 0, 1, 0, 0, 0, 0};
        rows[6]  = '{0, 'h26, 2,  1, 0, 0, 1, 0, 0, 0, 0};
        rows[7]  = '{0, 'h27, 4,  1, 0, 0, 1, 0, 0, 0, 0};
        rows[8]  = '{0, 'h2a, 19, 1, 0, 0, 1, 0, 0, 0, 0};
        rows[9]  = '{0, 'h2b, 20, 1, 0, 0, 1, 0, 0, 0, 0};
        rows[10] = '{0, 'h00, 16, 1, 0, 0, 1, 1, 0, 0, 0};
        rows[11] = '{0, 'h02, 17, 1, 0, 0, 1, 1, 0, 0, 0};
        rows[12] = '{0, 'h03, 18, 1, 0, 0, 1, 1, 0, 0, 0};
        rows[13] = '{0, 'h08, 0,  0, 0, 0, 1, 0, 0, 0, 4};
        rows[14] = '{'h08, -1, 0,  1, 0, 0, 0, 0, 1, 0, 0};
        rows[15] = '{'h09, -1, 0,  1, 0, 0, 0, 0, 1, 0, 0};
        rows[16] = '{'h0a, -1, 19, 1, 0, 0, 0, 0, 1, 0, 0};
        rows[17] = '{'h0b, -1, 20, 1, 0, 0, 0, 0, 1, 0, 0};
        rows[18] = '{'h0c, -1, 6,  1, 0, 0, 0, 0, 1, 1, 0};
        rows[19] = '{'h0d, -1, 8,  1, 0, 0, 0, 0, 1, 1, 0};
        rows[20] = '{'h0e, -1, 7,  1, 0, 0, 0, 0, 1, 1, 0};
        rows[21] = '{'h23, -1, 0,  1, 1, 0, 0, 0, 1, 0, 0};
        rows[22] = '{'h2b, -1, 0,  0, 0, 1, 0, 0, 1, 0, 0};
        rows[23] = '{'h04, -1, 0,  0, 0, 0, 0, 0, 0, 0, 1};
        rows[24] = '{'h05, -1, 0,  0, 0, 0, 0, 0, 0, 0, 2};
        rows[25] = '{'h02, -1, 0,  0, 0, 0, 0, 0, 0, 0, 3};

        rst_n               = 1'b1;
        bus.Instruction_id  = 32'h0800_000b;
        bus.NextPC_id       = 32'd0;
        bus.RegWrite_wb     = 1'b0;
        bus.RegWriteAddr_wb = 5'd0;
        bus.RegWriteData_wb = 32'd0;
        bus.MemRead_ex      = 1'b0;
        bus.RegWriteAddr_ex = 5'd0;
        #1 rst_n = 1'b0;
        #1 cmpEn = 1'b1;

        // Decode during reset: j 0xB
        check32("rst_J", 32'(bus.J), 32'd1);
        check32("rst_JumpAddr", bus.JumpAddr, 32'h0000_002c);
        check32("rst_RegWrite", 32'(bus.RegWrite_id), 32'd0);
        check32("rst_MemWrite", 32'(bus.MemWrite_id), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        setIn(32'h2008_0042, 32'd4);
        check32("addi_ALUCode", 32'(bus.ALUCode_id), 32'd0);
        check32("addi_ALUSrcB", 32'(bus.ALUSrcB_id), 32'd1);
        check32("addi_RegDst", 32'(bus.RegDst_id), 32'd0);
        check32("addi_RegWrite", 32'(bus.RegWrite_id), 32'd1);
        check32("addi_Imm", bus.Imm_id, 32'h42);
        check32("addi_RtAddr", 32'(bus.RtAddr_id), 32'd8);

        setIn(32'h000c_4080, 32'd8);
        check32("sll_ALUCode", 32'(bus.ALUCode_id), 32'd16);
        check32("sll_ALUSrcA", 32'(bus.ALUSrcA_id), 32'd1);
        check32("sll_Sa", bus.Sa_id, 32'd2);
        check32("sll_RdAddr", 32'(bus.RdAddr_id), 32'd8);

        setIn(32'h0109_5022, 32'd12);
        check32("sub_ALUCode", 32'(bus.ALUCode_id), 32'd5);
        check32("sub_RegDst", 32'(bus.RegDst_id), 32'd1);
        check32("sub_RdAddr", 32'(bus.RdAddr_id), 32'd10);

        // WB write of $15 alongside a read of $15
        @(posedge clk);
        #1;
        bus.Instruction_id  = 32'h01e0_0020;
        bus.RegWrite_wb     = 1'b1;
        bus.RegWriteAddr_wb = 5'd15;
        bus.RegWriteData_wb = 32'hf;
        #1;
`ifdef ID_BYPASS_EN
        check32("bypass_same_cycle", bus.RsData_id, 32'hf);
`else
        check32("nobypass_same_cycle", bus.RsData_id, 32'h0);
`endif
        @(posedge clk);
        #1 bus.RegWrite_wb = 1'b0;
        #1 check32("wb_after_edge", bus.RsData_id, 32'hf);

        bus.MemRead_ex      = 1'b1;
        bus.RegWriteAddr_ex = 5'd8;
        setIn(32'h0109_5022, 32'd16);
        check32("stall_Stall", 32'(bus.Stall), 32'd1);
        check32("stall_PC_IFWrite", 32'(bus.PC_IFWrite), 32'd0);
        check32("stall_RegWrite", 32'(bus.RegWrite_id), 32'd0);
        bus.RegWriteAddr_ex = 5'd0;
        #1;
        check32("nostall_r0_Stall", 32'(bus.Stall), 32'd0);
        check32("nostall_RegWrite", 32'(bus.RegWrite_id), 32'd1);
        bus.MemRead_ex = 1'b0;

        setIn(32'h1000_fff4, 32'h34);
        check32("beq_Z", 32'(bus.Z), 32'd1);
        check32("beq_BranchAddr", bus.BranchAddr, 32'h4);
        setIn(32'h1400_0001, 32'h34);
        check32("bne_Z", 32'(bus.Z), 32'd0);

        // Randomized phase with a mid-run asynchronous reset
        for (int n = 0; n < 2000; n++) begin
            randomCycle();
            if (n == 1000) #2 rst_n = 1'b0;
            if (n == 1003) rst_n = 1'b1;
        end
        @(posedge clk);
        #1 cmpEn = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the 5-stage 32-bit MIPS pipeline, between the IF/ID and ID/EX pipeline registers. Decodes the current instruction into datapath control, holds the 32×32 register file (written from WB), resolves branches and jumps in ID, and detects load-use hazards. It drives the stall and PC/IF-write controls back to fetch.

## Interface
Parameters: none.
- clk  in  1  pipeline clock; register-file writes on rising edge
- rst_n  in  1  asynchronous active-low reset
- Instruction_id  in  32  instruction in ID
- NextPC_id  in  32  PC+4 of that instruction
- RegWrite_wb / RegWriteAddr_wb / RegWriteData_wb  in  1/5/32  WB write port
- MemRead_ex / RegWriteAddr_ex  in  1/5  EX-stage load flag and destination
- MemtoReg_id, RegWrite_id, MemWrite_id, MemRead_id  out  1 each  control to EX
- ALUCode_id  out  5  ALU operation
- ALUSrcA_id  out  1  1: ALU A = Sa_id, 0: Rs
- ALUSrcB_id  out  1  1: ALU B = Imm_id, 0: Rt
- RegDst_id  out  1  1: dest = rd, 0: dest = rt
- Stall, PC_IFWrite  out  1 each  load-use stall; PC_IFWrite = ~Stall
- Z, J, JR  out  1 each  branch taken, jump, jump-register
- BranchAddr, JumpAddr, JrAddr  out  32 each  targets
- Imm_id, Sa_id, RsData_id, RtData_id  out  32 each  operands
- RsAddr_id, RtAddr_id, RdAddr_id  out  5 each  instr[25:21], [20:16], [15:11]

## Operation
- Supported: R-type add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, jr; addi, addiu, andi, ori, xori, slti, sltiu, lw, sw, beq, bne; j. Anything else decodes as NOP (all control 0, ALUCode ADD).
- ALUCode: ADD=0, AND=1, XOR=2, OR=3, NOR=4, SUB=5, ANDI=6, XORI=7, ORI=8, SLL=16, SRL=17, SRA=18, SLT=19, SLTU=20. addu/addi/addiu/lw/sw→ADD; subu→SUB; slti→SLT; sltiu→SLTU.
- RegWrite=1 for ALU R-type and I-type ALU ops and lw. MemRead=MemtoReg=1 for lw only. MemWrite=1 for sw only. RegDst=1 for R-type. ALUSrcA=1 for sll/srl/sra. ALUSrcB=1 for I-type ALU, lw and sw.
- Imm_id: zero-extended for andi/ori/xori; otherwise sign-extended. Sa_id = {27'b0, instr[10:6]}.
- Z = (beq & RsData==RtData) | (bne & RsData!=RtData). BranchAddr = NextPC_id + (sext(imm)<<2).
- J=1 for j; JumpAddr = {NextPC_id[31:28], instr[25:0], 2'b00}. JR=1 for jr; JrAddr = RsData_id.
- Stall = MemRead_ex & RegWriteAddr_ex≠0 & (RegWriteAddr_ex==RsAddr | RegWriteAddr_ex==RtAddr). While Stall: RegWrite, MemWrite, MemRead and MemtoReg are forced 0; Z, J and JR are forced 0.
- Register file: $0 reads 0, writes to $0 ignored.

## Timing
- All outputs combinational from Instruction_id, NextPC_id, EX/WB inputs and register contents; zero latency.
- Register write on rising clk when RegWrite_wb.
- rst_n low clears all 32 registers to 0 asynchronously. With rst_n low, outputs remain valid decodes of the inputs and read 0 data.
- Simultaneous WB write and ID read of the same nonzero register: see Configuration.

## Configuration
- ID_BYPASS_EN defined: a read of the register written this cycle by WB (addr≠0, RegWrite_wb=1) returns RegWriteData_wb combinationally.
- ID_BYPASS_EN undefined: reads return stored contents; the new value is visible after the clock edge.

## Test plan
- Reset; Instruction_id=0x0800000B, NextPC=0 -> J=1, JumpAddr=0x0000002C, RegWrite/MemWrite=0.
- 0x20080042 (addi $t0,$0,0x42) -> ALUCode=0, ALUSrcB=1, RegDst=0, RegWrite=1, Imm_id=0x42, RtAddr=8.
- 0x000C4080 (sll $t0,$t4,2) -> ALUCode=16, ALUSrcA=1, Sa_id=2, RdAddr=8. 0x01095022 (sub) -> ALUCode=5, RegDst=1, RdAddr=10.
- WB writes $15=0xF and ID reads with 0x01E00020 -> RsData=0xF in the same cycle with ID_BYPASS_EN, and after the edge without it.
- MemRead_ex=1, RegWriteAddr_ex=8, instr 0x01095022 -> Stall=1, PC_IFWrite=0, RegWrite_id=0. RegWriteAddr_ex=0 -> Stall=0.
- 0x1000FFF4 (beq $0,$0), NextPC=0x34 -> Z=1, BranchAddr=0x4. 0x14000001 (bne $0,$0) -> Z=0.
